// File: rtl/matrix_coprocessor_seq.sv
// Sequential matrix coprocessor: element-wise add/sub with saturation or
// sum-of-products convolution, one element per clock through a single lane.

module matrix_coproc_lane #(
  parameter int ELEM_W = 8,
  parameter int ACC_W  = 21
) (
  input  logic                     sub,
  input  logic signed [ELEM_W-1:0] a,
  input  logic signed [ELEM_W-1:0] b,
  input  logic signed [ACC_W-1:0]  acc_in,
  output logic signed [ELEM_W-1:0] sat,
  output logic signed [ACC_W-1:0]  acc_out
);
  logic signed [ELEM_W:0]     sum;
  logic signed [2*ELEM_W-1:0] prod;

  always_comb begin
    sum = sub ? ({a[ELEM_W-1], a} - {b[ELEM_W-1], b})
              : ({a[ELEM_W-1], a} + {b[ELEM_W-1], b});
    // top two bits disagree -> result left the ELEM_W range
    if (sum[ELEM_W] != sum[ELEM_W-1])
      sat = sum[ELEM_W] ? {1'b1, {(ELEM_W-1){1'b0}}} : {1'b0, {(ELEM_W-1){1'b1}}};
    else
      sat = sum[ELEM_W-1:0];
    prod    = a * b;
    acc_out = acc_in + {{(ACC_W-2*ELEM_W){prod[2*ELEM_W-1]}}, prod};
  end
endmodule

module matrix_coprocessor_seq #(
  parameter int ELEM_W = 8,
  parameter int MAX_N  = 5,
  parameter int ACC_W  = 21
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [2:0]                       op_code,
  input  logic [1:0]                       matrix_size,
  input  logic [MAX_N*MAX_N*ELEM_W-1:0]    matrix_a,
  input  logic [MAX_N*MAX_N*ELEM_W-1:0]    matrix_b,
  output logic                             busy,
  output logic                             process_done,
  output logic                             op_error,
  output logic [MAX_N*MAX_N*ELEM_W-1:0]    result_final
);
  localparam int NE = MAX_N*MAX_N;
  localparam int BW = NE*ELEM_W;
  localparam int CW = $clog2(MAX_N+1);
  localparam int IW = $clog2(NE);
  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_CONV = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef struct packed {
    logic [2:0]    op;
    logic [CW-1:0] n;
  } cfg_t;

  state_t            state, state_n;
  cfg_t              cfg_q;
  logic              err_q, accept, valid_op, last;
  logic [CW-1:0]     n_in, row, col;
  logic [IW-1:0]     idx;
  logic [BW-1:0]     a_q, b_q, work_q, work_nx;
  logic [ELEM_W-1:0] a_el, b_el, sat;
  logic [ACC_W-1:0]  acc_q, acc_nx;

  assign valid_op = (op_code == OP_ADD) || (op_code == OP_SUB) || (op_code == OP_CONV);
  assign n_in     = (int'(matrix_size) + 2 > MAX_N) ? CW'(MAX_N) : CW'(int'(matrix_size) + 2);
  assign idx      = IW'(int'(row) * MAX_N + int'(col));
  assign a_el     = a_q[int'(idx)*ELEM_W +: ELEM_W];
  assign b_el     = b_q[int'(idx)*ELEM_W +: ELEM_W];
  assign last     = (row == cfg_q.n - CW'(1)) && (col == cfg_q.n - CW'(1));

  matrix_coproc_lane #(.ELEM_W(ELEM_W), .ACC_W(ACC_W)) u_lane (
    .sub     (cfg_q.op == OP_SUB),
    .a       (a_el),
    .b       (b_el),
    .acc_in  (acc_q),
    .sat     (sat),
    .acc_out (acc_nx)
  );

  always_comb begin
    work_nx = work_q;
    work_nx[int'(idx)*ELEM_W +: ELEM_W] = sat;
  end

  always_comb begin
    state_n      = state;
    accept       = 1'b0;
    busy         = 1'b0;
    process_done = 1'b0;
    op_error     = 1'b0;
    case (state)
      IDLE, DONE: begin
        process_done = (state == DONE);
        op_error     = (state == DONE) && err_q;
        if (start) begin
          accept  = 1'b1;
          state_n = valid_op ? RUN : DONE;
        end else if (state == DONE) begin
          state_n = IDLE;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cfg_q        <= '0;
      err_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      work_q       <= '0;
      row          <= '0;
      col          <= '0;
      result_final <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        if (valid_op) begin
          cfg_q  <= '{op: op_code, n: n_in};
          a_q    <= matrix_a;
          b_q    <= matrix_b;
          acc_q  <= '0;
          work_q <= '0;
          row    <= '0;
          col    <= '0;
          err_q  <= 1'b0;
        end else begin
          // invalid op skips RUN and reports an all-zero result
          err_q        <= 1'b1;
          result_final <= '0;
        end
      end else if (state == RUN) begin
        acc_q  <= acc_nx;
        work_q <= work_nx;
        if (col == cfg_q.n - CW'(1)) begin
          col <= '0;
          row <= row + CW'(1);
        end else begin
          col <= col + CW'(1);
        end
        if (last)
          result_final <= (cfg_q.op == OP_CONV)
                          ? {{(BW-ACC_W){acc_nx[ACC_W-1]}}, acc_nx}
                          : work_nx;
      end
    end
  end
endmodule

// File: tb/tb_matrix_coprocessor_seq.sv
// Directed bench for matrix_coprocessor_seq: vector table plus control corner cases.

module tb_matrix_coprocessor_seq;
  localparam int EW = 8;
  localparam int MN = 5;
  localparam int AW = 21;
  localparam int W  = MN*MN*EW;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [2:0]   op_code;
  logic [1:0]   matrix_size;
  logic [W-1:0] matrix_a, matrix_b, result_final;
  logic         busy, process_done, op_error;

  int checks = 0;
  int errors = 0;

  matrix_coprocessor_seq #(.ELEM_W(EW), .MAX_N(MN), .ACC_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op_code      (op_code),
    .matrix_size  (matrix_size),
    .matrix_a     (matrix_a),
    .matrix_b     (matrix_b),
    .busy         (busy),
    .process_done (process_done),
    .op_error     (op_error),
    .result_final (result_final)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [1:0]   size;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_res;
    logic         exp_err;
    int           exp_lat;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [W-1:0] put(input logic [W-1:0] m, input int r, input int c, input int v);
    logic [W-1:0] t;
    t = m;
    t[(r*MN+c)*EW +: EW] = v[EW-1:0];
    return t;
  endfunction

  function automatic logic [W-1:0] fill(input int v);
    logic [W-1:0] t;
    t = '0;
    for (int i = 0; i < MN*MN; i++) t[i*EW +: EW] = v[EW-1:0];
    return t;
  endfunction

  function automatic logic [W-1:0] sx(input int v);
    return {{(W-32){v[31]}}, v};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input int i);
    op_code     = vecs[i].op;
    matrix_size = vecs[i].size;
    matrix_a    = vecs[i].a;
    matrix_b    = vecs[i].b;
  endtask

  task automatic launch();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges after the accepting edge until process_done, bounded.
  task automatic wait_check(input string name, input int exp_lat, input logic [W-1:0] exp_res,
                            input logic exp_err, input logic exp_busy, input int already);
    int edges;
    int bad;
    edges = already;
    bad   = 0;
    while (process_done !== 1'b1 && edges < 40) begin
      if (busy !== exp_busy) bad++;
      @(posedge clk); #1;
      edges++;
    end
    chk({name, "_latency"}, edges, exp_lat);
    chk({name, "_result"}, result_final, exp_res);
    chk({name, "_op_error"}, op_error, exp_err);
    chk({name, "_busy_run"}, bad, 0);
    chk({name, "_busy_done"}, busy, 1'b0);
  endtask

  task automatic run_vec(input int i);
    apply(i);
    launch();
    wait_check(vecs[i].name, vecs[i].exp_lat, vecs[i].exp_res, vecs[i].exp_err, vecs[i].exp_lat != 0, 0);
    @(posedge clk); #1;
    chk({vecs[i].name, "_pulse"}, process_done, 1'b0);
    chk({vecs[i].name, "_held"}, result_final, vecs[i].exp_res);
  endtask

  initial begin
    int spurious;

    vecs[0] = '{"conv2", 3'b111, 2'd0,
                put(put(put(put(put('0,0,0,1),0,1,2),1,0,3),1,1,4),2,2,99),
                put(put(put(put(put('0,0,0,5),0,1,6),1,0,7),1,1,8),2,2,99),
                sx(70), 1'b0, 4};
    vecs[1] = '{"conv5", 3'b111, 2'd3, fill(127), fill(-128), sx(-406400), 1'b0, 25};
    vecs[2] = '{"add3", 3'b000, 2'd1,
                put(put(put(put(put('0,0,0,100),1,1,-100),2,2,3),3,0,60),0,4,-9),
                put(put(put(put('0,0,0,100),1,1,-100),2,2,-5),3,0,60),
                put(put(put('0,0,0,127),1,1,-128),2,2,-2), 1'b0, 9};
    vecs[3] = '{"inv011", 3'b011, 2'd3, fill(1), fill(1), '0, 1'b1, 0};
    vecs[4] = '{"sub4", 3'b001, 2'd2,
                put(put(put(put('0,3,3,-100),0,1,10),2,0,100),4,0,77),
                put(put(put(put('0,3,3,100),0,1,4),2,0,-100),4,4,-77),
                put(put(put('0,3,3,-128),0,1,6),2,0,127), 1'b0, 16};
    vecs[5] = '{"conv3", 3'b111, 2'd1, fill(1), fill(-1), sx(-9), 1'b0, 9};
    vecs[6] = '{"conv2big", 3'b111, 2'd0, fill(127), fill(-128), sx(-65024), 1'b0, 4};
    vecs[7] = '{"inv110", 3'b110, 2'd0, fill(3), fill(3), '0, 1'b1, 0};

    reset = 1'b1; start = 1'b0; op_code = '0; matrix_size = '0;
    matrix_a = '0; matrix_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", process_done, 1'b0);
    chk("rst_err", op_error, 1'b0);
    chk("rst_result", result_final, '0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec(i);

    // inputs change and start is re-asserted while running: no effect
    apply(4);
    launch();
    repeat (3) @(posedge clk);
    #1;
    matrix_a = fill(-1);
    op_code  = 3'b111;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_check("sub4_midrun", 16, vecs[4].exp_res, 1'b0, 1'b1, 4);
    @(posedge clk); #1;

    // back-to-back: new start accepted in the DONE cycle
    apply(2);
    launch();
    wait_check("b2b_first", 9, vecs[2].exp_res, 1'b0, 1'b1, 0);
    apply(0);
    launch();
    wait_check("b2b_second", 4, sx(70), 1'b0, 1'b1, 0);
    @(posedge clk); #1;

    // reset at element 10 of a 5x5 run
    apply(1);
    launch();
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", process_done, 1'b0);
    chk("abort_err", op_error, 1'b0);
    chk("abort_result", result_final, '0);
    spurious = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (process_done !== 1'b0 || busy !== 1'b0) spurious++;
    end
    chk("abort_no_done", spurious, 0);
    run_vec(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/matrix_coprocessor_seq.md
Name: matrix_coprocessor_seq

Overview:
- Sequential, parametrised successor to the combinational convolution coprocessor.
- Executes element-wise add, element-wise subtract, or convolution (sum of products) on square matrices of size 2x2 to MAX_NxMAX_N.
- Uses one multiply-accumulate/ALU lane and processes one element per clock under a start/done handshake.
- Sits between the host-side matrix register bank and the result register, replacing the fixed-width combinational path.

Parameters:
- ELEM_W, 8: width of one signed two's-complement matrix element.
- MAX_N, 5: maximum matrix dimension; bus element count is MAX_N*MAX_N.
- ACC_W, 21: convolution accumulator width; must be >= 2*ELEM_W + ceil(log2(MAX_N*MAX_N)).

Ports:
- clk  in  1: clock; all logic on rising edge.
- reset  in  1: synchronous, active-high reset.
- start  in  1: request a new operation; sampled only when idle.
- op_code  in  3: 3'b000 add, 3'b001 subtract, 3'b111 convolution; all other values are invalid.
- matrix_size  in  2: active dimension N = matrix_size+2; values giving N > MAX_N are clamped to MAX_N.
- matrix_a  in  MAX_N*MAX_N*ELEM_W: element (r,c) at [(r*MAX_N+c)*ELEM_W +: ELEM_W].
- matrix_b  in  MAX_N*MAX_N*ELEM_W: same layout as matrix_a (kernel for convolution).
- busy  out  1: high while an operation is in progress.
- process_done  out  1: single-cycle pulse when result_final is updated.
- op_error  out  1: pulses together with process_done when op_code was invalid.
- result_final  out  MAX_N*MAX_N*ELEM_W: result; held stable until the next accepted start.

Behaviour:
- Reset: state=IDLE; busy=0, process_done=0, op_error=0, result_final=0; accumulator and indices cleared.
- Reset mid-operation aborts with no done pulse; any partial result is discarded.

State machine: IDLE, RUN, DONE.
- IDLE or DONE, start=1, valid op:
  - latch op_code, N, matrix_a and matrix_b into internal registers;
  - clear accumulator, working result and index;
  - go to RUN.
- Inputs may change freely after the accepting edge.
- IDLE or DONE, start=1, invalid op: go to DONE next edge with op_error=1 and result_final=0.
- DONE lasts exactly one cycle, then returns to IDLE unless start is accepted on that edge. Back-to-back operations are therefore allowed.
- RUN:
  - each edge processes one active element, row-major from (0,0) to (N-1,N-1): N*N edges in total;
  - busy=1 for the whole state;
  - start is ignored.
- On the edge processing the last element:
  - result_final is written;
  - state becomes DONE and process_done=1 for that one cycle.
- Latency: process_done is visible after the N*N-th rising edge following the accepting edge (2x2: 4 edges, 5x5: 25 edges).

Arithmetic:
- Add/subtract:
  - per-element signed result computed at ELEM_W+1 bits;
  - saturated to [-2^(ELEM_W-1), 2^(ELEM_W-1)-1];
  - written at the same (r,c) position;
  - elements outside the NxN region are 0.
- Convolution:
  - acc += a(r,c)*b(r,c) as full signed products, accumulated at ACC_W bits with no saturation (the width is sized to never overflow);
  - result_final[ACC_W-1:0] = acc;
  - bits above ACC_W are the sign extension of acc.
- Only indices r,c < N are read. Elements outside the active region never affect the result.

Test Plan:
- Convolution 2x2 (size=0): a=[1,2,3,4], b=[5,6,7,8], start for 1 cycle -> busy for 4 cycles; process_done after edge 4; result_final=70 (sign-extended).
- Convolution 5x5 (size=3): a all 127, b all -128 -> result -406400 sign-extended; done after exactly 25 edges; elements outside the region have no effect.
- Add 3x3 with saturation: a(0,0)=100, b(0,0)=100 -> 127; a(1,1)=-100, b(1,1)=-100 -> -128; a(2,2)=3, b(2,2)=-5 -> -2; all elements outside 3x3 are 0.
- Subtract 4x4: a(3,3)=-100, b(3,3)=100 -> -128; a(0,1)=10, b(0,1)=4 -> 6. Changing matrix_a during RUN must not change the result.
- Invalid op 3'b011 -> one edge later process_done=1, op_error=1, result_final=0; busy never asserts.
- Control:
  - start during RUN -> ignored, no restart;
  - reset asserted at element 10 of a 5x5 run -> outputs cleared next edge, no done pulse;
  - a new start after reset completes normally;
  - start asserted in the DONE cycle -> accepted, back-to-back operation.
